// File: rtl/hc_pkg.sv
// Shared types and configuration helpers for the HC-series counter and flip-flop blocks.
package hc_pkg;

    typedef enum logic {
        HC_UP = 1'b0,
        HC_DN = 1'b1
    } hc_dir_e;

    localparam int unsigned HC_WIDTH_MIN = 2;
    localparam int unsigned HC_WIDTH_MAX = 16;

    // Terminal value when counting up: the last legal state before wrapping to zero.
    function automatic int unsigned hc_term_value(input int unsigned modulus);
        return modulus - 1;
    endfunction

    function automatic bit hc_cfg_ok(input int unsigned width, input int unsigned modulus);
        return (width >= HC_WIDTH_MIN) && (width <= HC_WIDTH_MAX) &&
               (modulus >= 2) && (modulus <= (32'd1 << width));
    endfunction

endpackage

// File: rtl/hc190_sync_counter_if.sv
// Control, load-data and status bundle of the presettable up/down counter.
interface hc190_sync_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             Load_N;
    logic             CtEn_N;
    logic             DnUp;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Q_N;
    logic             MaxMin;
    logic             Rco_N;

    modport master (
        output Load_N, CtEn_N, DnUp, D,
        input  Q, Q_N, MaxMin, Rco_N
    );

    modport slave (
        input  Load_N, CtEn_N, DnUp, D,
        output Q, Q_N, MaxMin, Rco_N
    );
endinterface

// File: rtl/hc190_sync_counter_mod_step.sv
// Combinational modulo step: next counter value and terminal-count flag for one direction.
module hc_mod_step
    import hc_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic [WIDTH-1:0] q,
    input  hc_dir_e          dir,
    output logic [WIDTH-1:0] q_next,
    output logic             is_term
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(hc_term_value(MODULUS));

    // Out-of-range values wrap to zero going up and decrement back into range going down.
    always_comb begin
        q_next  = q;
        is_term = 1'b0;
        if (dir == HC_DN) begin
            q_next  = (q == '0) ? TERM : q - WIDTH'(1);
            is_term = (q == '0);
        end else begin
            q_next  = (q >= TERM) ? '0 : q + WIDTH'(1);
            is_term = (q == TERM);
        end
    end

endmodule

// File: rtl/hc190_sync_counter.sv
// Synchronous presettable up/down modulo counter (HC190/HC191 style) with cascade outputs.
// HC190_RCO_REG_EN: when defined, Rco_N is registered one cycle late instead of combinational.
module hc190_sync_counter
    import hc_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic                 Clk,
    input  logic                 R,
    hc190_sync_counter_if.slave  bus
);

    if (!hc_cfg_ok(WIDTH, MODULUS)) begin : g_bad_cfg
        $error("hc190_sync_counter: unsupported WIDTH/MODULUS combination");
    end

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    logic             is_term;
    hc_dir_e          dir;

    assign dir = hc_dir_e'(bus.DnUp);

    hc_mod_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_step (
        .q       (q_r),
        .dir     (dir),
        .q_next  (q_next),
        .is_term (is_term)
    );

    // Reset beats load, load beats count.
    always_ff @(posedge Clk) begin
        if (!R) begin
            q_r <= '0;
        end else if (!bus.Load_N) begin
            q_r <= bus.D;
        end else if (!bus.CtEn_N) begin
            q_r <= q_next;
        end
    end

    assign bus.Q      = q_r;
    assign bus.Q_N    = ~q_r;
    assign bus.MaxMin = is_term;

`ifdef HC190_RCO_REG_EN
    logic rco_n_r;

    // Samples the carry condition at the edge, so the low pulse trails the terminal state by one cycle.
    always_ff @(posedge Clk) begin
        if (!R) begin
            rco_n_r <= 1'b1;
        end else begin
            rco_n_r <= ~(is_term & ~bus.CtEn_N);
        end
    end

    assign bus.Rco_N = rco_n_r;
`else
    assign bus.Rco_N = ~(is_term & ~bus.CtEn_N & R);
`endif

endmodule

// File: tb/tb_hc190_sync_counter.sv
// Scoreboard bench for hc190_sync_counter: directed single-instance vectors plus cascades.
module tb_hc190_sync_counter;

    typedef struct {
        logic [3:0] q;
        logic       mm;
        logic       rco;
    } exp_t;

    typedef struct {
        logic [3:0] lo;
        logic [3:0] hi;
        logic [3:0] b;
        logic       brco;
    } cexp_t;

    logic clk;
    logic rst_n;
    logic rc_n;

    int n_vec;
    int n_err;

    exp_t  sb[$];
    cexp_t csb[$];

    hc190_sync_counter_if #(.WIDTH(4)) bus ();
    hc190_sync_counter_if #(.WIDTH(4)) bus_lo ();
    hc190_sync_counter_if #(.WIDTH(4)) bus_hi ();
    hc190_sync_counter_if #(.WIDTH(4)) bus_b ();

    hc190_sync_counter #(.WIDTH(4), .MODULUS(10)) dut    (.Clk(clk), .R(rst_n), .bus(bus));
    hc190_sync_counter #(.WIDTH(4), .MODULUS(10)) dut_lo (.Clk(clk), .R(rc_n),  .bus(bus_lo));
    hc190_sync_counter #(.WIDTH(4), .MODULUS(10)) dut_hi (.Clk(clk), .R(rc_n),  .bus(bus_hi));
    hc190_sync_counter #(.WIDTH(4), .MODULUS(16)) dut_b  (.Clk(clk), .R(rc_n),  .bus(bus_b));

    assign bus_hi.CtEn_N = bus_lo.Rco_N;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Main-DUT monitor: one expectation per clock edge that had a vector issued.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("q",      int'(bus.Q),      int'(e.q));
            chk("q_n",    int'(bus.Q_N),    int'(4'(~e.q)));
            chk("maxmin", int'(bus.MaxMin), int'(e.mm));
`ifndef HC190_RCO_REG_EN
            chk("rco_n",  int'(bus.Rco_N),  int'(e.rco));
`endif
        end
    end

    // Cascade monitor.
    always @(posedge clk) begin
        cexp_t c;
        #1;
        if (csb.size() > 0) begin
            c = csb.pop_front();
            chk("casc_lo",  int'(bus_lo.Q),  int'(c.lo));
            chk("casc_hi",  int'(bus_hi.Q),  int'(c.hi));
            chk("bin_q",    int'(bus_b.Q),   int'(c.b));
            chk("bin_rco",  int'(bus_b.Rco_N), int'(c.brco));
        end
    end

    task automatic apply(input logic r, input logic ld, input logic ce, input logic du,
                         input logic [3:0] d, input logic [3:0] eq, input logic emm,
                         input logic erco);
        exp_t e;
        @(negedge clk);
        rst_n      = r;
        bus.Load_N = ld;
        bus.CtEn_N = ce;
        bus.DnUp   = du;
        bus.D      = d;
        e.q = eq; e.mm = emm; e.rco = erco;
        sb.push_back(e);
    endtask

    task automatic capply(input logic r, input logic [3:0] lo, input logic [3:0] hi,
                          input logic [3:0] b, input logic brco);
        cexp_t c;
        @(negedge clk);
        rc_n = r;
        c.lo = lo; c.hi = hi; c.b = b; c.brco = brco;
        csb.push_back(c);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        rc_n  = 1'b0;
        bus.Load_N = 1'b1; bus.CtEn_N = 1'b0; bus.DnUp = 1'b0; bus.D = 4'd0;
        bus_lo.Load_N = 1'b1; bus_lo.CtEn_N = 1'b0; bus_lo.DnUp = 1'b0; bus_lo.D = 4'd0;
        bus_hi.Load_N = 1'b1; bus_hi.DnUp = 1'b0; bus_hi.D = 4'd0;
        bus_b.Load_N  = 1'b1; bus_b.CtEn_N  = 1'b0; bus_b.DnUp  = 1'b0; bus_b.D  = 4'd0;

        // Reset: MaxMin follows DnUp, Rco_N forced high even with count enabled.
        apply(0, 1, 0, 0, 4'd0, 4'd0, 0, 1);
        apply(0, 1, 0, 1, 4'd0, 4'd0, 1, 1);

        // Decade count up 1..9,0,1.
        for (int i = 1; i <= 11; i++) begin
            logic [3:0] q;
            q = 4'(i % 10);
            apply(1, 1, 0, 0, 4'd0, q, (q == 4'd9), (q == 4'd9) ? 1'b0 : 1'b1);
        end

        // Illegal preload, wrap up to zero; reload and count down into range.
        apply(1, 0, 1, 0, 4'hC, 4'd12, 0, 1);
        apply(1, 1, 0, 0, 4'h0, 4'd0,  0, 1);
        apply(1, 0, 1, 0, 4'hC, 4'd12, 0, 1);
        apply(1, 1, 0, 1, 4'h0, 4'd11, 0, 1);
        apply(1, 1, 0, 1, 4'h0, 4'd10, 0, 1);
        apply(1, 1, 0, 1, 4'h0, 4'd9,  0, 1);
        apply(1, 0, 1, 1, 4'hF, 4'd15, 0, 1);
        apply(1, 1, 0, 1, 4'h0, 4'd14, 0, 1);

        // Down through zero to MODULUS-1, then direction flip at 9.
        apply(1, 0, 1, 1, 4'd1, 4'd1, 0, 1);
        apply(1, 1, 0, 1, 4'd0, 4'd0, 1, 0);
        apply(1, 1, 0, 1, 4'd0, 4'd9, 0, 1);
        apply(1, 1, 1, 0, 4'd0, 4'd9, 1, 1);
        apply(1, 1, 0, 0, 4'd0, 4'd0, 0, 1);

        // Load beats count; disabled count holds and masks Rco_N.
        apply(1, 0, 1, 0, 4'd7, 4'd7, 0, 1);
        apply(1, 0, 0, 0, 4'd3, 4'd3, 0, 1);
        apply(1, 1, 1, 0, 4'd0, 4'd3, 0, 1);
        apply(1, 0, 1, 0, 4'd9, 4'd9, 1, 1);
        apply(1, 1, 1, 0, 4'd0, 4'd9, 1, 1);

        // Reset beats load mid-count, then counting resumes.
        apply(1, 0, 1, 0, 4'd6, 4'd6, 0, 1);
        apply(0, 0, 0, 0, 4'd5, 4'd0, 0, 1);
        apply(0, 0, 0, 1, 4'd5, 4'd0, 1, 1);
        apply(1, 1, 0, 0, 4'd0, 4'd1, 0, 1);
        apply(1, 1, 0, 0, 4'd0, 4'd2, 0, 1);

        // Cascade (decade pair) and a standalone binary counter.
        capply(0, 4'd0, 4'd0, 4'd0, 1);
        capply(0, 4'd0, 4'd0, 4'd0, 1);
        for (int n = 1; n <= 100; n++) begin
            logic [3:0] lo, hi, b;
            logic       brco;
            lo = 4'(n % 10);
            b  = 4'(n % 16);
`ifdef HC190_RCO_REG_EN
            hi   = 4'(((n - 1) / 10) % 10);
            brco = (((n - 1) % 16) == 15) ? 1'b0 : 1'b1;
`else
            hi   = 4'((n / 10) % 10);
            brco = (b == 4'd15) ? 1'b0 : 1'b1;
`endif
            capply(1, lo, hi, b, brco);
        end

        repeat (4) @(posedge clk);
        #2;
        if (sb.size() != 0 || csb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d/%0d expectations left, required 0", sb.size(), csb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
